// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory port: FSM state encoding and access-size constants.
package lc3b_types;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_port_state_t;

    localparam logic ACC_WORD = 1'b0;
    localparam logic ACC_BYTE = 1'b1;

    typedef struct packed {
        logic write;
        logic size;
    } acc_flags_t;

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane steering: store replication, byte-enable decode, load extract/zero-extend.
module mem_byte_lane
    import lc3b_types::*;
#(
    parameter  int WIDTH  = 16,
    localparam int LANES  = WIDTH / 8,
    localparam int LANE_W = $clog2(LANES)
) (
    input  logic [LANE_W-1:0] lane,
    input  logic              size,
    input  logic [WIDTH-1:0]  wdata_raw,
    input  logic [WIDTH-1:0]  rdata_raw,
    output logic [WIDTH-1:0]  wdata_lane,
    output logic [LANES-1:0]  byte_enable,
    output logic [WIDTH-1:0]  rdata_ext
);

    logic [7:0] rd_byte;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        wdata_lane  = wdata_raw;
        byte_enable = '1;
        rd_byte     = rdata_raw[{lane, 3'b000} +: 8];
        rdata_ext   = rdata_raw;
        if (size == ACC_BYTE) begin
            // The memory picks the target byte from the enables, so every lane carries the same byte.
            wdata_lane        = {LANES{wdata_raw[7:0]}};
            byte_enable       = '0;
            byte_enable[lane] = 1'b1;
            rdata_ext         = {{(WIDTH-8){1'b0}}, rd_byte};
        end
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory port controller: IDLE/ACCESS/DONE handshake between datapath and a single-port memory.
// Optional access timeout is enabled by defining MEM_PORT_TIMEOUT_EN.
module mem_port_ctrl
    import lc3b_types::*;
#(
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic                 req_byte,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    output logic                 rsp_valid,
    output logic [WIDTH-1:0]     rsp_rdata,
    output logic                 rsp_err,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [ADDR_W-1:0]    mem_address,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic [WIDTH/8-1:0]   mem_byte_enable,
    input  logic [WIDTH-1:0]     mem_rdata,
    input  logic                 mem_resp
);

    localparam int LANES  = WIDTH / 8;
    localparam int LANE_W = $clog2(LANES);

    mem_port_state_t state, state_next;

    logic [ADDR_W-1:0] mar;
    logic [WIDTH-1:0]  mdr;
    acc_flags_t        flags;

    logic              in_idle, in_access, accept, resp_hit, timeout_hit;
    logic [LANE_W-1:0] lane_sel;
    logic              size_sel;
    logic [WIDTH-1:0]  lane_wdata, lane_rdata;
    logic [LANES-1:0]  lane_be;

    assign in_idle   = (state == ST_IDLE);
    assign in_access = (state == ST_ACCESS);
    assign accept    = in_idle && req_valid;
    assign resp_hit  = in_access && mem_resp;

    // One steering instance serves both phases: request fields while idle, latched MAR/flags afterwards.
    assign lane_sel = in_idle ? req_addr[LANE_W-1:0] : mar[LANE_W-1:0];
    assign size_sel = in_idle ? req_byte : flags.size;

    mem_byte_lane #(.WIDTH(WIDTH)) u_lane (
        .lane        (lane_sel),
        .size        (size_sel),
        .wdata_raw   (req_wdata),
        .rdata_raw   (mem_rdata),
        .wdata_lane  (lane_wdata),
        .byte_enable (lane_be),
        .rdata_ext   (lane_rdata)
    );

`ifdef MEM_PORT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] to_cnt;
    logic             err_q;

    // Count holds the number of ACCESS cycles already spent, so the abort lands on cycle TIMEOUT.
    assign timeout_hit = in_access && !mem_resp && (to_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= in_access ? to_cnt + 1'b1 : '0;
            if (accept)
                err_q <= 1'b0;
            else if (timeout_hit)
                err_q <= 1'b1;
        end
    end

    assign rsp_err = (state == ST_DONE) && err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT == 0);
    assign timeout_hit        = 1'b0;
    assign rsp_err            = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (req_valid) state_next = ST_ACCESS;
            ST_ACCESS: if (mem_resp || timeout_hit) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // MDR is cleared for stores and aborts so rsp_rdata can simply present it in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar   <= '0;
            mdr   <= '0;
            flags <= '{write: 1'b0, size: ACC_WORD};
        end else if (accept) begin
            mar   <= req_addr;
            mdr   <= lane_wdata;
            flags <= '{write: req_write, size: req_byte};
        end else if (resp_hit) begin
            mdr <= flags.write ? '0 : lane_rdata;
        end else if (timeout_hit) begin
            mdr <= '0;
        end
    end

    assign req_ready       = in_idle;
    assign mem_read        = in_access && !flags.write;
    assign mem_write       = in_access && flags.write;
    assign mem_address     = mar;
    assign mem_wdata       = mdr;
    assign mem_byte_enable = in_access ? lane_be : '0;
    assign rsp_valid       = (state == ST_DONE);
    assign rsp_rdata       = (state == ST_DONE) ? mdr : '0;

endmodule
